// File: rtl/mc_ctrl_fsm_hs.sv
// mc_ctrl_fsm_hs: multi-cycle CPU control FSM with ready handshake on IF/MEM and timeout trap; optional PERF_CNT_EN counters
module mc_ctrl_fsm_hs #(
  parameter int ALUOP_W = 3,
  parameter int TMO_MAX = 255,
  parameter int TMO_W   = 16
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W   = 32
`endif
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         Opcode,
  input  logic               zero,
  input  logic               sign,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic [3:0]         state,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWre,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               DBDataSrc,
  output logic               WrRegDSrc,
  output logic               ExtSel,
  output logic               InsMemRW,
  output logic               nRD,
  output logic               nWR,
  output logic [1:0]         RegDst,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               halted,
  output logic               bus_err
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
`endif
);
  localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_EXAL = 4'd2, S_EXBR = 4'd3, S_EXLS = 4'd4;
  localparam logic [3:0] S_MEM = 4'd5, S_WBAL = 4'd6, S_WBLD = 4'd7, S_HALT = 4'd8;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND = 6'b010000, OP_ANDI = 6'b010001, OP_ORI = 6'b010010;
  localparam logic [5:0] OP_SLL = 6'b011000, OP_SLTI = 6'b100110;
  localparam logic [5:0] OP_SW = 6'b110000, OP_LW = 6'b110001;
  localparam logic [5:0] OP_BEQ = 6'b110100, OP_BNE = 6'b110101, OP_BLTZ = 6'b110110;
  localparam logic [5:0] OP_J = 6'b111000, OP_JR = 6'b111001, OP_JAL = 6'b111010, OP_HALT = 6'b111111;
  logic [3:0]       state_nx;
  logic [TMO_W-1:0] tmo_cnt;
  logic             is_al, is_rtype, is_lw, is_sw, is_br, is_jmp, is_jal, is_halt, is_nop;
  logic             br_taken, waiting, tmo_hit;
  logic [2:0]       alu_code;
  assign is_al    = Opcode inside {OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLL, OP_SLTI};
  assign is_rtype = Opcode inside {OP_ADD, OP_SUB, OP_AND, OP_SLL};
  assign is_lw    = Opcode == OP_LW;
  assign is_sw    = Opcode == OP_SW;
  assign is_br    = Opcode inside {OP_BEQ, OP_BNE, OP_BLTZ};
  assign is_jmp   = Opcode inside {OP_J, OP_JR, OP_JAL};
  assign is_jal   = Opcode == OP_JAL;
  assign is_halt  = Opcode == OP_HALT;
  assign is_nop   = !(is_al || is_lw || is_sw || is_br || is_jmp || is_halt);
  assign br_taken = Opcode == OP_BEQ ? zero : Opcode == OP_BNE ? !zero : Opcode == OP_BLTZ ? sign : 1'b0;
  assign waiting  = (state == S_IF && !imem_ready) || (state == S_MEM && !dmem_ready);
  assign tmo_hit  = waiting && tmo_cnt == TMO_W'(TMO_MAX - 1);
  assign alu_code = Opcode inside {OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ} ? 3'd1 :
                    Opcode inside {OP_AND, OP_ANDI} ? 3'd2 :
                    Opcode == OP_ORI ? 3'd3 :
                    Opcode == OP_SLL ? 3'd4 :
                    Opcode == OP_SLTI ? 3'd5 : 3'd0;

  // State register; the wait counter runs only while stalled, so any non-wait cycle leaves it cleared for the next IF/MEM
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state   <= S_IF;
      tmo_cnt <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= waiting ? tmo_cnt + TMO_W'(1) : '0;
      bus_err <= bus_err | tmo_hit;
    end
  end

  // Next-state sequencing; a ready on the limit cycle suppresses the timeout because tmo_hit requires waiting
  always_comb begin
    state_nx = S_IF;
    case (state)
      S_IF:   state_nx = tmo_hit ? S_HALT : imem_ready ? S_ID : S_IF;
      S_ID:   state_nx = is_al ? S_EXAL : (is_lw || is_sw) ? S_EXLS : is_br ? S_EXBR : is_halt ? S_HALT : S_IF;
      S_EXAL: state_nx = S_WBAL;
      S_EXBR: state_nx = S_IF;
      S_EXLS: state_nx = S_MEM;
      S_MEM:  state_nx = tmo_hit ? S_HALT : !dmem_ready ? S_MEM : is_lw ? S_WBLD : S_IF;
      S_WBAL: state_nx = S_IF;
      S_WBLD: state_nx = S_IF;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_IF;
    endcase
  end

  // Datapath controls decoded from the registered state and the held opcode
  always_comb begin
    InsMemRW  = state == S_IF;
    IRWre     = state == S_IF && imem_ready;
    PCWre     = (state == S_ID && (is_jmp || is_nop)) || state == S_EXBR || (state == S_MEM && dmem_ready && is_sw) ||
                state == S_WBAL || state == S_WBLD;
    RegWre    = state == S_WBAL || state == S_WBLD || (state == S_ID && is_jal);
    RegDst    = (state == S_ID && is_jal) ? 2'b10 : (state == S_WBAL && is_rtype) ? 2'b01 : 2'b00;
    WrRegDSrc = !(state == S_ID && is_jal);
    DBDataSrc = state == S_WBLD;
    nRD       = !(state == S_MEM && is_lw);
    nWR       = !(state == S_MEM && is_sw);
    PCSrc     = state == S_ID ? (Opcode == OP_JR ? 2'b10 : (Opcode == OP_J || is_jal) ? 2'b11 : 2'b00) :
                (state == S_EXBR && br_taken) ? 2'b01 : 2'b00;
    ALUSrcA   = Opcode == OP_SLL;
    ALUSrcB   = Opcode inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW};
    ExtSel    = !(Opcode inside {OP_ANDI, OP_ORI});
    ALUOp     = ALUOP_W'(alu_code);
    halted    = state == S_HALT;
  end

`ifdef PERF_CNT_EN
  // Cycle and retired-instruction counters; entering HALT retires the halt (or trapped) instruction
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (PCWre || (state != S_HALT && state_nx == S_HALT)) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif
endmodule
